// File: rtl/angle_reduce_if.sv
// Request/result bundle for the tangent angle reducer.
// Latency: n/a (wiring only).
// Backpressure: none; the master must watch busy/done, since start is ignored while busy.
//
// Signals:
//   start        request pulse, sampled only while the reducer is idle
//   a            signed input angle, integer degrees
//   reduced_deg  signed equivalent tangent angle in [-90,90]
//   pole         reduced angle is +/-90 (tangent undefined)
//   error        input out of range (tied low unless range checking is built in)
//   busy         reducer is working on a request
//   done         one-cycle pulse when the result outputs are valid
interface angle_reduce_if #(
  parameter int INPUTOUTBIT = 16
) ();

  logic                          start;
  logic signed [INPUTOUTBIT-1:0] a;
  logic signed [INPUTOUTBIT-1:0] reduced_deg;
  logic                          pole;
  logic                          error;
  logic                          busy;
  logic                          done;

  modport master (
    output start,
    output a,
    input  reduced_deg,
    input  pole,
    input  error,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a,
    output reduced_deg,
    output pole,
    output error,
    output busy,
    output done
  );

endinterface

// File: rtl/angle_reduce.sv
// Reduces an integer-degree angle to the equivalent tangent angle in [-90,90].
// Latency: done k+4 cycles after start is sampled, where k = floor(|a|/180).
// Backpressure: start is ignored while busy; results hold until the next accepted start.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    angle_reduce_if.slave: start/a in; reduced_deg/pole/error/busy/done out
//
// Optional feature: define ANGLE_RANGE_CHECK_EN to reject inputs outside
// [-999,999]. Such inputs raise error with a zero result, and done arrives two
// cycles after start. Without the macro, error is tied low and every input
// is reduced. The worst case is a = -32768, at 186 cycles.
module angle_reduce #(
  parameter int INPUTOUTBIT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  angle_reduce_if.slave bus
);

  localparam int W  = INPUTOUTBIT;
  // One extra bit so that |-2^(W-1)| is representable without overflow.
  localparam int MW = INPUTOUTBIT + 1;

  localparam logic [MW-1:0] M180 = MW'(180);
  localparam logic [MW-1:0] M90  = MW'(90);
  localparam logic [W-1:0]  K180 = W'(180);
  localparam logic [W-1:0]  K0   = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SUB,
    MAP
  } state_t;

  state_t                state;
  logic signed [W-1:0]   a_q;      // input latched on an accepted start
  logic                  neg_q;    // sign of the latched input
  logic [MW-1:0]         m_q;      // magnitude, folded down modulo 180
  logic signed [W-1:0]   red_q;
  logic                  pole_q;
  logic                  busy_q;
  logic                  done_q;

  // Magnitude of the latched input. It is computed in MW bits, so -32768 maps to +32768.
  logic [MW-1:0] a_ext;
  logic [MW-1:0] abs_a;
  assign a_ext = {a_q[W-1], a_q};
  assign abs_a = a_q[W-1] ? ((~a_ext) + MW'(1)) : a_ext;

  logic m_ge_180;
  logic m_gt_90;
  assign m_ge_180 = (m_q >= M180);
  assign m_gt_90  = (m_q >  M90);

  // In MAP, m < 180, so the low W bits carry the whole magnitude.
  logic [W-1:0] m_lo;
  assign m_lo = m_q[W-1:0];

  // The fold (m-180) and the sign negation are merged into a single subtract
  // against a constant, so each path holds one adder behind a 4:1 mux.
  //   a>=0, m<=90 :  m
  //   a>=0, m>90  :  m - 180
  //   a<0,  m<=90 : -m
  //   a<0,  m>90  :  180 - m
  logic [W-1:0] map_r;
  always_comb begin
    map_r = '0;
    unique case ({neg_q, m_gt_90})
      2'b00:   map_r = m_lo;
      2'b01:   map_r = m_lo - K180;
      2'b10:   map_r = K0 - m_lo;
      2'b11:   map_r = K180 - m_lo;
      default: map_r = '0;
    endcase
  end

`ifdef ANGLE_RANGE_CHECK_EN
  localparam logic signed [W-1:0] A_MAX = 999;
  localparam logic signed [W-1:0] A_MIN = -999;

  logic err_q;
  logic out_of_range;
  assign out_of_range = (a_q > A_MAX) || (a_q < A_MIN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      neg_q  <= 1'b0;
      m_q    <= '0;
      red_q  <= '0;
      pole_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ANGLE_RANGE_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            busy_q <= 1'b1;
            state  <= LOAD;
`ifdef ANGLE_RANGE_CHECK_EN
            err_q  <= 1'b0;
`endif
          end
        end

        LOAD: begin
          neg_q <= a_q[W-1];
          m_q   <= abs_a;
`ifdef ANGLE_RANGE_CHECK_EN
          if (out_of_range) begin
            // Reject the input without reducing it; SUB and MAP are skipped.
            err_q  <= 1'b1;
            red_q  <= '0;
            pole_q <= 1'b0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            state  <= SUB;
          end
`else
          state <= SUB;
`endif
        end

        SUB: begin
          // One subtraction of 180 per cycle, repeated until m < 180.
          if (m_ge_180) begin
            m_q <= m_q - M180;
          end else begin
            state <= MAP;
          end
        end

        MAP: begin
          red_q  <= map_r;
          // |r| == 90 exactly when the folded magnitude is 90.
          pole_q <= (m_q == M90);
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.reduced_deg = red_q;
  assign bus.pole        = pole_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
`ifdef ANGLE_RANGE_CHECK_EN
  assign bus.error       = err_q;
`else
  assign bus.error       = 1'b0;
`endif

endmodule

// File: tb/tb_angle_reduce.sv
// Directed bench for angle_reduce: hand-computed results, latencies and interference cases.
// Latency is counted in cycles after the cycle in which start is presented.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_angle_reduce;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  angle_reduce_if #(.INPUTOUTBIT(16)) bus ();

  angle_reduce #(.INPUTOUTBIT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present a request for one cycle; the caller is left in cycle N.
  task automatic start_op(input int a);
    @(negedge clk);
    bus.a     = 16'(a);
    bus.start = 1'b1;
  endtask

  // Run one request and check the result, the latency, the done pulse width and the result hold.
  task automatic run_op(input string tag, input int a, input int er, input int ep,
                        input int ee, input int el);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    start_op(a);
    while (!seen && lat < 400) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      if (lat == 1) check({tag, ".busy"}, int'(bus.busy), 1);
      if (bus.done) seen = 1'b1;
    end
    check({tag, ".lat"}, seen ? lat : -1, el);
    check({tag, ".red"}, int'(bus.reduced_deg), er);
    check({tag, ".pole"}, int'(bus.pole), ep);
    check({tag, ".err"}, int'(bus.error), ee);
    @(negedge clk);
    check({tag, ".done_pulse"}, int'(bus.done), 0);
    check({tag, ".hold"}, int'(bus.reduced_deg), er);
  endtask

  initial begin
    int lat;
    int ndone;
    int first;
    bus.start = 1'b0;
    bus.a     = '0;

    repeat (3) @(negedge clk);
    check("rst.red",  int'(bus.reduced_deg), 0);
    check("rst.pole", int'(bus.pole), 0);
    check("rst.err",  int'(bus.error), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //      tag        a       red  pole err lat
    run_op("a45",      45,     45,  0,   0,  4);
    run_op("a999",     999,    -81, 0,   0,  9);
    run_op("a270",     270,    90,  1,   0,  5);
    run_op("a-450",    -450,   -90, 1,   0,  6);
    run_op("a-100",    -100,   80,  0,   0,  4);
    run_op("a0",       0,      0,   0,   0,  4);
    run_op("a91",      91,     -89, 0,   0,  4);
    run_op("a-90",     -90,    -90, 1,   0,  4);
    run_op("a180",     180,    0,   0,   0,  5);
    run_op("a-999",    -999,   81,  0,   0,  9);
`ifdef ANGLE_RANGE_CHECK_EN
    run_op("a1200",    1200,   0,   0,   1,  2);
    run_op("a-32768",  -32768, 0,   0,   1,  2);
    // An accepted start clears a pending error.
    run_op("clr_err",  45,     45,  0,   0,  4);
`else
    run_op("a1200",    1200,   -60, 0,   0,  10);
    run_op("a-32768",  -32768, -8,  0,   0,  186);
`endif

    // A start raised while busy must not disturb the operation in flight.
    start_op(999);
    lat   = 0;
    ndone = 0;
    first = -1;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        bus.a     = 16'(10);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        if (first < 0) begin
          first = lat;
          check("busy_start.red", int'(bus.reduced_deg), -81);
        end
      end
    end
    check("busy_start.ndone", ndone, 1);
    check("busy_start.lat", first, 9);

    // A reset mid-operation aborts it silently and clears the outputs.
    start_op(999);
    lat = 0;
    while (lat < 3) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst.red",  int'(bus.reduced_deg), 0);
    check("mid_rst.pole", int'(bus.pole), 0);
    check("mid_rst.err",  int'(bus.error), 0);
    check("mid_rst.busy", int'(bus.busy), 0);
    check("mid_rst.done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("mid_rst.ndone", ndone, 0);
    run_op("post_rst", 30, 30, 0, 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/angle_reduce.md
ANGLE_REDUCE -- requirements
Module: angle_reduce

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have `start`, input, 1 bit: request pulse; sampled only in IDLE.
REQ-004 SHALL have `a`, input, `INPUTOUTBIT` (16) bits, signed: integer degrees.
REQ-005 SHALL have `reduced_deg`, output, 16 bits, signed: equivalent tangent angle in [-90,90] degrees.
REQ-006 SHALL have `pole`, output, 1 bit: reduced angle is +90 or -90 (tangent undefined).
REQ-007 SHALL have `error`, output, 1 bit: input out of range; only when ANGLE_RANGE_CHECK_EN is defined.
REQ-008 SHALL have `busy`, output, 1 bit: high in every non-IDLE state.
REQ-009 SHALL have `done`, output, 1 bit: one-cycle pulse when outputs are valid.

Function
REQ-010 SHALL implement states IDLE, LOAD, SUB, MAP.
REQ-011 IDLE with start=1 SHALL latch `a` and go to LOAD; start=0 SHALL stay in IDLE.
REQ-012 LOAD SHALL store sign(a) and m=|a| as a 17-bit unsigned value, so |-32768| is exact; then go to SUB.
REQ-013 SUB with m>=180 SHALL perform m<=m-180 and stay in SUB (one subtraction per cycle, no divider or % operator).
REQ-014 SUB with m<180 SHALL go to MAP.
REQ-015 MAP SHALL compute r = (m>90) ? m-180 : m, negate r when a<0, register reduced_deg=r, register pole=(|r|==90), pulse done, and return to IDLE.
REQ-016 Result SHALL satisfy tan(reduced_deg)=tan(a); the sign of a ±90 result follows the sign of the input.
REQ-017 Latency: with start sampled at cycle N and k=floor(|a|/180), done SHALL be high in cycle N+k+4.
REQ-018 Worst-case latency for |a|<=999 SHALL be 9 cycles.
REQ-019 start asserted while busy=1 SHALL be ignored; the operation in flight SHALL be unaffected.
REQ-020 reduced_deg, pole and error SHALL hold their values from done until the next accepted start.
REQ-021 On an accepted start, error SHALL be cleared.
REQ-022 a=0 SHALL yield reduced_deg=0, pole=0.
REQ-023 Critical path SHALL be at most one 17-bit add/compare, meeting 300 MHz.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, reduced_deg=0, pole=0, error=0, busy=0, done=0, and clear the internal m and sign registers.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-026 The first start accepted after release SHALL behave as from power-up.

Configuration
REQ-027 Macro ANGLE_RANGE_CHECK_EN, when defined, SHALL make LOAD check the input range:
- a outside [-999,999] sets error=1, reduced_deg=0, pole=0.
- done pulses in cycle N+2; SUB and MAP are skipped.
REQ-028 Without ANGLE_RANGE_CHECK_EN:
- error SHALL be tied to 0.
- Every 16-bit input SHALL be reduced per REQ-013..015.
- Latency is up to 186 cycles for a=-32768.

Verification
REQ-029 Basic case: a=45 -> reduced_deg=45, pole=0, done at N+4.
REQ-030 Maximum positive input: a=999 -> reduced_deg=-81, pole=0, done at N+9.
REQ-031 Poles:
- a=270 -> reduced_deg=90, pole=1, done at N+5.
- a=-450 -> reduced_deg=-90, pole=1, done at N+6.
REQ-032 Negative input: a=-100 -> reduced_deg=80, pole=0.
REQ-033 Out-of-range input a=1200:
- With ANGLE_RANGE_CHECK_EN: error=1, reduced_deg=0, done at N+2.
- Without: reduced_deg=-60, error=0, done at N+10.
REQ-034 Interference:
- start=1 with a=10 at N+3 during a=999 -> single done at N+9 with reduced_deg=-81.
- rst_n=0 at N+3 -> no done; outputs 0; next a=30 -> reduced_deg=30.
